collision_detect: RTL and testbench

Downstream consumer of the enemy-update stage. Once per frame tick it snapshots the packed enemy slot vector and the player's bounding box, then scans the slots sequentially, one per clock. Each live enemy is tested against the player with an axis-aligned overlap test. It reports a per-slot hit mask, the lowest hit index and a sticky game-over flag for the game-control FSM.

---
 rtl/collision_detect.sv | 197 +++++++++++++++++++
 tb/tb_collision_detect.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_detect.sv
// Frame-tick collision scanner: snapshots enemy slots and the player box, tests one
// slot per clock with a strict AABB overlap, and reports a hit mask and sticky game_over.
module collision_detect #(
    parameter int unsigned SLOTS      = 7,
    parameter int unsigned TYPELEN    = 2,
    parameter int unsigned XLEN       = 10,
    parameter int unsigned YLEN       = 9,
    parameter int unsigned WLEN       = 7,
    parameter int unsigned HLEN       = 7,
    parameter int unsigned ENEMY_TYPE = 2
) (
    input  logic                                             clk3,
    input  logic                                             rst_n,
    input  logic [(TYPELEN+XLEN+YLEN+WLEN+HLEN)*SLOTS-1:0]   gamedata,
    input  logic [XLEN-1:0]                                  player_x,
    input  logic [YLEN-1:0]                                  player_y,
    input  logic [WLEN-1:0]                                  player_w,
    input  logic [HLEN-1:0]                                  player_h,
    input  logic                                             start,
    input  logic                                             clear_go,
    output logic                                             busy,
    output logic                                             done,
    output logic                                             hit,
    output logic [SLOTS-1:0]                                 hit_mask,
    output logic [2:0]                                       hit_index,
    output logic                                             game_over
);

    localparam int unsigned DATALEN = TYPELEN + XLEN + YLEN + WLEN + HLEN;
    localparam int unsigned GDLEN   = DATALEN * SLOTS;
    localparam int unsigned IDXW    = 3;
    localparam int unsigned X_OFS   = TYPELEN;
    localparam int unsigned Y_OFS   = X_OFS + XLEN;
    localparam int unsigned W_OFS   = Y_OFS + YLEN;
    localparam int unsigned H_OFS   = W_OFS + WLEN;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [GDLEN-1:0]    snap_data_q, snap_data_d;
    logic [XLEN-1:0]     snap_px_q, snap_px_d;
    logic [YLEN-1:0]     snap_py_q, snap_py_d;
    logic [WLEN-1:0]     snap_pw_q, snap_pw_d;
    logic [HLEN-1:0]     snap_ph_q, snap_ph_d;
    logic [SLOTS-1:0]    mask_q, mask_d;
    logic [SLOTS-1:0]    hit_mask_q, hit_mask_d;
    logic                hit_q, hit_d;
    logic [IDXW-1:0]     hit_index_q, hit_index_d;
    logic                game_over_q, game_over_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    logic [DATALEN-1:0]  slot_c;
    logic [TYPELEN-1:0]  e_type_c;
    logic [XLEN-1:0]     e_x_c;
    logic [YLEN-1:0]     e_y_c;
    logic [WLEN-1:0]     e_w_c;
    logic [HLEN-1:0]     e_h_c;
    logic                live_c;
    logic                overlap_c;
    logic                slot_hit_c;

    function automatic logic [IDXW-1:0] lowest_set(input logic [SLOTS-1:0] m);
        lowest_set = '0;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            if (m[k]) lowest_set = IDXW'(k);
        end
    endfunction

    // Select the snapshot slot currently under evaluation.
    always_comb begin
        slot_c = '0;
        for (int k = 0; k < SLOTS; k++) begin
            if (idx_q == IDXW'(k)) slot_c = snap_data_q[k*DATALEN +: DATALEN];
        end
    end

    assign e_type_c = slot_c[TYPELEN-1:0];
    assign e_x_c    = slot_c[X_OFS +: XLEN];
    assign e_y_c    = slot_c[Y_OFS +: YLEN];
    assign e_w_c    = slot_c[W_OFS +: WLEN];
    assign e_h_c    = slot_c[H_OFS +: HLEN];

    assign live_c = (e_type_c == TYPELEN'(ENEMY_TYPE));

    // Sums carry one extra bit so large coordinates never wrap; zero extents never overlap.
    always_comb begin
        overlap_c = ((XLEN+1)'(e_x_c) < (XLEN+1)'(snap_px_q) + (XLEN+1)'(snap_pw_q))
                 && ((XLEN+1)'(snap_px_q) < (XLEN+1)'(e_x_c) + (XLEN+1)'(e_w_c))
                 && ((YLEN+1)'(e_y_c) < (YLEN+1)'(snap_py_q) + (YLEN+1)'(snap_ph_q))
                 && ((YLEN+1)'(snap_py_q) < (YLEN+1)'(e_y_c) + (YLEN+1)'(e_h_c))
                 && (e_w_c != '0) && (e_h_c != '0)
                 && (snap_pw_q != '0) && (snap_ph_q != '0);
    end

    assign slot_hit_c = live_c && overlap_c;

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        snap_data_d = snap_data_q;
        snap_px_d   = snap_px_q;
        snap_py_d   = snap_py_q;
        snap_pw_d   = snap_pw_q;
        snap_ph_d   = snap_ph_q;
        mask_d      = mask_q;
        hit_mask_d  = hit_mask_q;
        hit_d       = hit_q;
        hit_index_d = hit_index_q;
        game_over_d = game_over_q && !clear_go;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    snap_data_d = gamedata;
                    snap_px_d   = player_x;
                    snap_py_d   = player_y;
                    snap_pw_d   = player_w;
                    snap_ph_d   = player_h;
                    mask_d      = '0;
                    idx_d       = '0;
                    state_d     = ST_SCAN;
                end
            end
            ST_SCAN: begin
                mask_d[idx_q] = slot_hit_c;
                if (idx_q == IDXW'(SLOTS - 1)) begin
                    state_d     = ST_REPORT;
                    hit_mask_d  = mask_d;
                    hit_d       = |mask_d;
                    hit_index_d = lowest_set(mask_d);
                    done_d      = 1'b1;
                    if (|mask_d) game_over_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk3) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            snap_data_q <= '0;
            snap_px_q   <= '0;
            snap_py_q   <= '0;
            snap_pw_q   <= '0;
            snap_ph_q   <= '0;
            mask_q      <= '0;
            hit_mask_q  <= '0;
            hit_q       <= 1'b0;
            hit_index_q <= '0;
            game_over_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            snap_data_q <= snap_data_d;
            snap_px_q   <= snap_px_d;
            snap_py_q   <= snap_py_d;
            snap_pw_q   <= snap_pw_d;
            snap_ph_q   <= snap_ph_d;
            mask_q      <= mask_d;
            hit_mask_q  <= hit_mask_d;
            hit_q       <= hit_d;
            hit_index_q <= hit_index_d;
            game_over_q <= game_over_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign hit       = hit_q;
    assign hit_mask  = hit_mask_q;
    assign hit_index = hit_index_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_collision_detect.sv
// Directed bench for collision_detect: hand-computed hit masks, timing, reset and sticky flag.
module tb_collision_detect;

    localparam int unsigned SLOTS   = 7;
    localparam int unsigned TYPELEN = 2;
    localparam int unsigned XLEN    = 10;
    localparam int unsigned YLEN    = 9;
    localparam int unsigned WLEN    = 7;
    localparam int unsigned HLEN    = 7;
    localparam int unsigned DATALEN = TYPELEN + XLEN + YLEN + WLEN + HLEN;

    logic                     clk3 = 1'b0;
    logic                     rst_n;
    logic [DATALEN*SLOTS-1:0] gamedata;
    logic [XLEN-1:0]          player_x;
    logic [YLEN-1:0]          player_y;
    logic [WLEN-1:0]          player_w;
    logic [HLEN-1:0]          player_h;
    logic                     start;
    logic                     clear_go;
    logic                     busy;
    logic                     done;
    logic                     hit;
    logic [SLOTS-1:0]         hit_mask;
    logic [2:0]               hit_index;
    logic                     game_over;

    int errors = 0;
    int checks = 0;

    collision_detect dut (
        .clk3      (clk3),
        .rst_n     (rst_n),
        .gamedata  (gamedata),
        .player_x  (player_x),
        .player_y  (player_y),
        .player_w  (player_w),
        .player_h  (player_h),
        .start     (start),
        .clear_go  (clear_go),
        .busy      (busy),
        .done      (done),
        .hit       (hit),
        .hit_mask  (hit_mask),
        .hit_index (hit_index),
        .game_over (game_over)
    );

    always #5 clk3 = ~clk3;

    function automatic logic [DATALEN-1:0] mk(input int t, input int x, input int y,
                                              input int w, input int h);
        return {HLEN'(h), WLEN'(w), YLEN'(y), XLEN'(x), TYPELEN'(t)};
    endfunction

    task automatic set_slot(input int k, input int t, input int x, input int y,
                            input int w, input int h);
        gamedata[k*DATALEN +: DATALEN] = mk(t, x, y, w, h);
    endtask

    task automatic set_player(input int x, input int y, input int w, input int h);
        player_x = XLEN'(x);
        player_y = YLEN'(y);
        player_w = WLEN'(w);
        player_h = HLEN'(h);
    endtask

    task automatic step();
        @(posedge clk3);
        #1;
    endtask

    // Starts a scan and returns the number of edges from E0 until done is seen.
    task automatic run_scan(output int lat);
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({busy, done, hit, hit_mask, hit_index, game_over} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want all zero",
                     {busy, done, hit, hit_mask, hit_index, game_over});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_empty();
        int lat;
        gamedata = '0;
        set_player(50, 100, 20, 30);
        run_scan(lat);
        checks++;
        if (lat !== 7) begin errors++; $display("FAIL empty_latency: got %0d want 7", lat); end
        checks++;
        if (hit !== 1'b0 || hit_mask !== 7'b0) begin
            errors++; $display("FAIL empty_hit: got hit=%b mask=%b want 0/0000000", hit, hit_mask);
        end
        checks++;
        if (game_over !== 1'b0) begin errors++; $display("FAIL empty_go: got %b want 0", game_over); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL report_busy: got %b want 1", busy); end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL done_fall: got done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    task automatic test_single_hit();
        int lat;
        gamedata = '0;
        set_slot(3, 2, 60, 110, 15, 15);
        run_scan(lat);
        checks++;
        if (lat !== 7) begin errors++; $display("FAIL hit_latency: got %0d want 7", lat); end
        checks++;
        if (hit !== 1'b1 || hit_mask !== 7'b0001000 || hit_index !== 3'd3) begin
            errors++;
            $display("FAIL single_hit: got hit=%b mask=%b idx=%0d want 1/0001000/3", hit, hit_mask, hit_index);
        end
        checks++;
        if (game_over !== 1'b1) begin errors++; $display("FAIL single_go: got %b want 1", game_over); end
        step();
        checks++;
        if (hit_mask !== 7'b0001000) begin
            errors++; $display("FAIL mask_held: got %b want 0001000", hit_mask);
        end
        clear_go = 1'b1;
        step();
        clear_go = 1'b0;
        checks++;
        if (game_over !== 1'b0) begin errors++; $display("FAIL clear_go: got %b want 0", game_over); end
    endtask

    task automatic test_touching();
        int lat;
        gamedata = '0;
        set_slot(2, 2, 70, 110, 15, 15);
        set_slot(5, 2, 30, 100, 20, 10);
        run_scan(lat);
        checks++;
        if (hit !== 1'b0 || hit_mask !== 7'b0) begin
            errors++; $display("FAIL touching: got hit=%b mask=%b want 0/0000000", hit, hit_mask);
        end
        step();
        set_slot(5, 2, 31, 100, 20, 10);
        run_scan(lat);
        checks++;
        if (hit_mask !== 7'b0100000 || hit_index !== 3'd5) begin
            errors++; $display("FAIL overlap_by_one: got mask=%b idx=%0d want 0100000/5", hit_mask, hit_index);
        end
        step();
    endtask

    task automatic test_multi();
        int lat;
        gamedata = '0;
        set_slot(1, 2, 55, 105, 5, 5);
        set_slot(4, 2, 40, 90, 20, 20);
        set_slot(6, 1, 55, 105, 5, 5);
        run_scan(lat);
        checks++;
        if (hit !== 1'b1 || hit_mask !== 7'b0010010 || hit_index !== 3'd1) begin
            errors++;
            $display("FAIL multi: got hit=%b mask=%b idx=%0d want 1/0010010/1", hit, hit_mask, hit_index);
        end
        step();
    endtask

    task automatic test_wrap();
        int lat;
        gamedata = '0;
        set_player(0, 100, 20, 30);
        set_slot(0, 2, 1020, 110, 127, 10);
        run_scan(lat);
        checks++;
        if (hit !== 1'b0 || hit_mask !== 7'b0) begin
            errors++; $display("FAIL no_wrap: got hit=%b mask=%b want 0/0000000", hit, hit_mask);
        end
        checks++;
        if (game_over !== 1'b1) begin errors++; $display("FAIL go_sticky: got %b want 1", game_over); end
        step();
        set_player(1000, 100, 30, 30);
        run_scan(lat);
        checks++;
        if (hit_mask !== 7'b0000001 || hit_index !== 3'd0) begin
            errors++; $display("FAIL wide_sum_hit: got mask=%b idx=%0d want 0000001/0", hit_mask, hit_index);
        end
        step();
    endtask

    task automatic test_snapshot();
        int lat;
        gamedata = '0;
        set_player(50, 100, 20, 30);
        set_slot(6, 2, 55, 105, 5, 5);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        gamedata = '0;
        set_slot(0, 2, 55, 105, 5, 5);
        set_player(500, 400, 1, 1);
        lat = 2;
        while (done !== 1'b1 && lat < 20) begin step(); lat++; end
        checks++;
        if (lat !== 7) begin errors++; $display("FAIL snap_latency: got %0d want 7", lat); end
        checks++;
        if (hit_mask !== 7'b1000000 || hit_index !== 3'd6) begin
            errors++; $display("FAIL snapshot: got mask=%b idx=%0d want 1000000/6", hit_mask, hit_index);
        end
        step();
        set_player(50, 100, 20, 30);
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        gamedata = '0;
        set_slot(3, 2, 60, 110, 15, 15);
        start = 1'b1;
        step();
        for (int c = 0; c < 25; c++) begin
            start = (c == 2 || c == 7);
            step();
            start = 1'b0;
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL start_ignored: got %0d dones want 1", dones); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_after: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_abort();
        int dones = 0;
        int lat;
        gamedata = '0;
        set_slot(3, 2, 60, 110, 15, 15);
        run_scan(lat);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if ({busy, done, hit, hit_mask, hit_index, game_over} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got %b want all zero",
                     {busy, done, hit, hit_mask, hit_index, game_over});
        end
        for (int c = 0; c < 12; c++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles want 0", dones); end
    endtask

    task automatic test_set_wins();
        gamedata = '0;
        set_slot(3, 2, 60, 110, 15, 15);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        clear_go = 1'b1;
        step();
        clear_go = 1'b0;
        checks++;
        if (done !== 1'b1 || game_over !== 1'b1) begin
            errors++; $display("FAIL set_wins: got done=%b go=%b want 1/1", done, game_over);
        end
        step();
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        clear_go = 1'b0;
        gamedata = '0;
        set_player(50, 100, 20, 30);
        step();
        test_reset();
        test_empty();
        test_single_hit();
        test_touching();
        test_multi();
        test_wrap();
        test_snapshot();
        test_back_to_back();
        test_reset_abort();
        test_set_wins();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
